dot_product_ctrl: RTL

Sequencing master for the shared 16-bit ALU in the matrix-multiply datapath. It computes one dot product of length `len` by fetching operand pairs from the operand memories and issuing MUL, ADD and SUB operations to the combinational ALU. It uses the ALU zero flag to detect loop termination and returns the accumulated element of the result matrix. It sits between the top-level matrix controller (start/done) and the ALU (in1/in2/alu_op in, alu_out/z back).

---
 rtl/mm_pkg.sv | 20 ++
 rtl/dot_product_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply datapath: ALU opcodes,
// the dot-product sequencer state encoding and the default data width.
package mm_pkg;

  localparam int DATA_W = 16;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_MUL = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_MUL   = 3'd2,
    ST_ACC   = 3'd3,
    ST_DEC   = 3'd4,
    ST_DONE  = 3'd5
  } dotp_state_e;

endpackage

// File: rtl/dot_product_ctrl.sv
// Dot-product sequencer driving the shared combinational ALU.
// Optional sticky accumulate-overflow flag: define DOTP_OVF_EN.
//
// state | meaning
// IDLE  | waiting for start; ALU parked at 0 + 0
// FETCH | rd_req held high until rd_valid delivers operand pair idx
// MUL   | ALU computes a * b
// ACC   | ALU computes acc + prod
// DEC   | ALU computes cnt - 1; zero flag ends the loop
// DONE  | done pulse, result valid
//
// The ALU operand registers are loaded on the transition into the state
// that uses them, so alu_in1/alu_in2/alu_op are purely registered. They
// double as the a/b and prod holding registers: the product captured in MUL
// is written straight into alu_in2 for the ACC step.
module dot_product_ctrl
  import mm_pkg::*;
#(
  parameter int DATA_W = mm_pkg::DATA_W,
  parameter int LEN_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              rd_req,
  output logic [LEN_W-1:0]  rd_idx,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_a,
  input  logic [DATA_W-1:0] rd_b,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_z,
  output logic              ovf
);

  dotp_state_e       state_q;
  logic              busy_q;
  logic              done_q;
  logic              rd_req_q;
  logic [DATA_W-1:0] result_q;
  logic [DATA_W-1:0] acc_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [LEN_W-1:0]  idx_q;
  logic [DATA_W-1:0] alu_in1_q;
  logic [DATA_W-1:0] alu_in2_q;
  logic [2:0]        alu_op_q;
`ifdef DOTP_OVF_EN
  logic              ovf_q;
`endif

  // Sequencer FSM with all outputs and datapath registers updated together
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_req_q  <= 1'b0;
      result_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      alu_in1_q <= '0;
      alu_in2_q <= '0;
      alu_op_q  <= ALU_ADD;
`ifdef DOTP_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cnt_q  <= len;
            acc_q  <= '0;
            idx_q  <= '0;
            busy_q <= 1'b1;
`ifdef DOTP_OVF_EN
            ovf_q  <= 1'b0;
`endif
            if (len == '0) begin
              result_q <= '0;
              done_q   <= 1'b1;
              state_q  <= ST_DONE;
            end else begin
              rd_req_q <= 1'b1;
              state_q  <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          if (rd_valid) begin
            rd_req_q  <= 1'b0;
            alu_in1_q <= rd_a;
            alu_in2_q <= rd_b;
            alu_op_q  <= ALU_MUL;
            state_q   <= ST_MUL;
          end
        end
        ST_MUL: begin
          alu_in1_q <= acc_q;
          alu_in2_q <= alu_out;
          alu_op_q  <= ALU_ADD;
          state_q   <= ST_ACC;
        end
        ST_ACC: begin
          acc_q     <= alu_out;
`ifdef DOTP_OVF_EN
          if (alu_out < acc_q) ovf_q <= 1'b1;
`endif
          alu_in1_q <= DATA_W'(cnt_q);
          alu_in2_q <= DATA_W'(1);
          alu_op_q  <= ALU_SUB;
          state_q   <= ST_DEC;
        end
        ST_DEC: begin
          cnt_q     <= alu_out[LEN_W-1:0];
          idx_q     <= idx_q + 1'b1;
          alu_in1_q <= '0;
          alu_in2_q <= '0;
          alu_op_q  <= ALU_ADD;
          if (alu_z) begin
            result_q <= acc_q;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end else begin
            rd_req_q <= 1'b1;
            state_q  <= ST_FETCH;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q   <= 1'b0;
          rd_req_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign rd_req  = rd_req_q;
  assign rd_idx  = idx_q;
  assign alu_in1 = alu_in1_q;
  assign alu_in2 = alu_in2_q;
  assign alu_op  = alu_op_q;
`ifdef DOTP_OVF_EN
  assign ovf     = ovf_q;
`else
  assign ovf     = 1'b0;
`endif

endmodule
